// File: rtl/cuenta1_arbiter_pkg.sv
// cuenta1_arbiter_pkg: shared FSM state encoding and default parameters.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cuenta1_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int N_REQ_DEF    = 2;
  localparam int VALOR_W_DEF  = 3;
  localparam int CUENTA_W_DEF = 4;
  localparam int TIMEOUT_DEF  = 15;

endpackage

// File: rtl/cuenta1_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select, first set req at or after ptr (wrapping).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is only consumed by the arbiter in IDLE.
// Ports: req (requests), ptr (highest-priority index) -> onehot/idx of winner, any = |req.
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jj     = '0;
    // Scan from ptr upward; the first hit wins, so ptr itself has top priority.
    for (int k = 0; k < N_REQ; k++) begin
      j  = (int'(ptr) + k) % N_REQ;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any        = 1'b1;
        idx        = jj;
        onehot[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cuenta1_arbiter.sv
// cuenta1_arbiter: shares one cuenta1 ones-counter among N_REQ requesters, round-robin.
// Latency: req seen in IDLE -> dp_start +2 cycles; done 1 cycle after fin sampled in WAIT.
// Backpressure: requesters hold req until done; a watchdog aborts a hung datapath (err).
// Ports: clk/reset (async, active-low); req/valor_in from clients; grant/done/cuenta_out/err
//        back to clients; busy status; dp_valor/dp_start to cuenta1, dp_fin/dp_cuenta from it.
module cuenta1_arbiter
  import cuenta1_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int VALOR_W  = VALOR_W_DEF,
  parameter int CUENTA_W = CUENTA_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*VALOR_W-1:0]   valor_in,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           done,
  output logic [CUENTA_W-1:0]        cuenta_out,
  output logic                       err,
  output logic                       busy,
  output logic [VALOR_W-1:0]         dp_valor,
  output logic                       dp_start,
  input  logic                       dp_fin,
  input  logic [CUENTA_W-1:0]        dp_cuenta
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win;
  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic               pick_any;
  logic [WD_W-1:0]    wd;
  logic               wd_expired;
  logic [CUENTA_W-1:0] res;
  logic               err_flag;
  logic [VALOR_W-1:0] op_sel;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign wd_expired = (wd == WD_W'(TIMEOUT));

  // Operand of the latched winner.
  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDX_W'(i)) op_sel = valor_in[i*VALOR_W +: VALOR_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    grant      = win_oh;
    done       = '0;
    cuenta_out = '0;
    err        = 1'b0;
    dp_start   = 1'b0;
    case (state)
      S_IDLE: begin
        busy  = 1'b0;
        grant = '0;
        if (pick_any) state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = S_START;
      S_START: begin
        dp_start  = 1'b1;
        state_nxt = S_WAIT;   // dp_fin deliberately not looked at: may be stale
      end
      S_WAIT:  if (dp_fin || wd_expired) state_nxt = S_DONE;
      S_DONE: begin
        done       = win_oh;
        cuenta_out = res;
        err        = err_flag;
        state_nxt  = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        grant     = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      win      <= '0;
      win_oh   <= '0;
      dp_valor <= '0;
      wd       <= '0;
      res      <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            win    <= pick_idx;
            win_oh <= pick_oh;
          end
        end
        S_LOAD:  dp_valor <= op_sel;
        S_START: begin
          wd       <= WD_W'(1);
          err_flag <= 1'b0;
        end
        S_WAIT: begin
          if (dp_fin) begin
            res <= dp_cuenta;
          end else if (wd_expired) begin
            res      <= '0;
            err_flag <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_DONE:  ptr <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
